// File: rtl/m_mem_ctrl_pkg.sv
// Shared CPU definitions for the M-stage data-memory controller:
// memory opcodes, FSM state encoding and access-size codes.
package m_mem_ctrl_pkg;

  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_SW  = 6'h2b;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SB  = 6'h28;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_BYTE = 2'd2;

  // Word accesses need addr[1:0]==0, halfword accesses need addr[0]==0.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_WORD: is_misaligned = |lane;
      SZ_HALF: is_misaligned = lane[0];
      default: is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/m_mem_ctrl_load_ext.sv
// Load lane selection and sign/zero extension of the raw memory word.
module load_ext
  import m_mem_ctrl_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] ldata
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (lane)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = lane[1] ? rdata[31:16] : rdata[15:0];

    case (size)
      SZ_HALF: ldata = {{16{sign_ext & half_sel[15]}}, half_sel};
      SZ_BYTE: ldata = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      default: ldata = rdata;
    endcase
  end

endmodule

// File: rtl/m_mem_ctrl.sv
// M-stage data-memory controller: decodes load/store ops, runs a single
// request/ready transaction per op and stalls the pipeline while it is open.
module m_mem_ctrl
  import m_mem_ctrl_pkg::*;
#(
  parameter logic [5:0] LW  = OP_LW,
  parameter logic [5:0] LH  = OP_LH,
  parameter logic [5:0] LHU = OP_LHU,
  parameter logic [5:0] LB  = OP_LB,
  parameter logic [5:0] LBU = OP_LBU,
  parameter logic [5:0] SW  = OP_SW,
  parameter logic [5:0] SH  = OP_SH,
  parameter logic [5:0] SB  = OP_SB
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  M_opcode,
  input  logic [31:0] M_ALUout,
  input  logic [31:0] M_r2,
  input  logic        M_hold,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_byteen,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        M_stall,
  output logic [31:0] M_ldata,
  output logic        M_ldata_valid,
  output logic        M_excAdEL,
  output logic        M_excAdES,
  output logic [1:0]  state_dbg
);

  // Handshake: mem_req stays high with mem_addr/mem_we/mem_byteen/mem_wdata
  // frozen until the first rising edge that samples mem_ready=1; mem_ready
  // at any other time carries no meaning and is ignored.

  state_t      state, state_next;
  logic        is_load, is_store, sign_ext, misaligned, go;
  logic [1:0]  size, lane;
  logic [3:0]  st_byteen;
  logic [31:0] st_wdata, ext_data;

  logic [29:0] addr_q;
  logic        we_q, load_q, sign_q;
  logic [3:0]  byteen_q;
  logic [31:0] wdata_q;
  logic [1:0]  lane_q, size_q;

  assign lane = M_ALUout[1:0];

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    size     = SZ_WORD;
    sign_ext = 1'b0;
    case (M_opcode)
      LW:  is_load = 1'b1;
      LH:  begin is_load = 1'b1; size = SZ_HALF; sign_ext = 1'b1; end
      LHU: begin is_load = 1'b1; size = SZ_HALF; end
      LB:  begin is_load = 1'b1; size = SZ_BYTE; sign_ext = 1'b1; end
      LBU: begin is_load = 1'b1; size = SZ_BYTE; end
      SW:  is_store = 1'b1;
      SH:  begin is_store = 1'b1; size = SZ_HALF; end
      SB:  begin is_store = 1'b1; size = SZ_BYTE; end
      default: ;
    endcase
  end

  assign misaligned = is_misaligned(size, lane);
  assign go         = (is_load | is_store) & ~misaligned;

  always_comb begin
    st_byteen = 4'b1111;
    st_wdata  = M_r2;
    case (size)
      SZ_HALF: begin
        st_byteen = 4'b0011 << {lane[1], 1'b0};
        st_wdata  = {2{M_r2[15:0]}};
      end
      SZ_BYTE: begin
        st_byteen = 4'b0001 << lane;
        st_wdata  = {4{M_r2[7:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (go) state_next = ST_REQ;
      ST_REQ:  if (mem_ready) state_next = ST_DONE;
      ST_DONE: if (!M_hold) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Transaction attributes are frozen on entry to REQ so the bus stays stable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q   <= '0;
      we_q     <= 1'b0;
      load_q   <= 1'b0;
      sign_q   <= 1'b0;
      byteen_q <= '0;
      wdata_q  <= '0;
      lane_q   <= '0;
      size_q   <= SZ_WORD;
    end else if (state == ST_IDLE && go) begin
      addr_q   <= M_ALUout[31:2];
      we_q     <= is_store;
      load_q   <= is_load;
      sign_q   <= sign_ext;
      byteen_q <= is_store ? st_byteen : 4'b0000;
      wdata_q  <= st_wdata;
      lane_q   <= lane;
      size_q   <= size;
    end
  end

  load_ext u_load_ext (
    .rdata    (mem_rdata),
    .lane     (lane_q),
    .size     (size_q),
    .sign_ext (sign_q),
    .ldata    (ext_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                    M_ldata <= '0;
    else if (state == ST_REQ && mem_ready && load_q) M_ldata <= ext_data;
  end

  assign mem_req       = (state == ST_REQ);
  assign mem_we        = mem_req & we_q;
  assign mem_byteen    = mem_req ? byteen_q : 4'b0000;
  assign mem_addr      = mem_req ? {addr_q, 2'b00} : {M_ALUout[31:2], 2'b00};
  assign mem_wdata     = mem_req ? wdata_q : st_wdata;
  assign M_ldata_valid = (state == ST_DONE) & load_q;

  // Gated by reset so the stall and exceptions drop the moment reset asserts.
  assign M_stall   = reset & (((state == ST_IDLE) & go) | mem_req);
  assign M_excAdEL = reset & (state == ST_IDLE) & is_load & misaligned;
  assign M_excAdES = reset & (state == ST_IDLE) & is_store & misaligned;
  assign state_dbg = state;

endmodule

// File: doc/m_mem_ctrl.md
M_MEM_CTRL -- requirements
Module: m_mem_ctrl

Interface
REQ-001 SHALL provide ports: clk  in  1  sole clock, rising edge; reset  in  1  asynchronous, active-low.
REQ-002 SHALL provide M-stage inputs from the E->M register: M_opcode in 6, M_ALUout in 32 (byte address), M_r2 in 32 (store data), M_hold in 1 (M->W register will not advance this cycle).
REQ-003 SHALL provide data-memory initiator ports: mem_req out 1, mem_we out 1, mem_addr out 32 (word-aligned), mem_byteen out 4, mem_wdata out 32, mem_ready in 1, mem_rdata in 32.
REQ-004 SHALL provide pipeline outputs: M_stall out 1, M_ldata out 32 (extended load result), M_ldata_valid out 1, M_excAdEL out 1, M_excAdES out 1.
REQ-005 SHALL use these parameters, with their defaults and meanings: LW=6'h23, LH=6'h21, LHU=6'h25, LB=6'h20, LBU=6'h24, SW=6'h2b, SH=6'h29, SB=6'h28 (memory opcodes; any other opcode is a non-memory op).

Function
REQ-006 SHALL implement FSM states IDLE, REQ, DONE.
REQ-007 IDLE + aligned memory op SHALL go to REQ on the next edge; M_stall SHALL be 1 combinationally in that cycle.
REQ-008 IDLE + non-memory op SHALL keep IDLE; M_stall=0, mem_req=0.
REQ-009 IDLE + misaligned op SHALL keep IDLE, issue no request, hold M_stall=0, and assert M_excAdEL (loads) or M_excAdES (stores) combinationally. Misaligned means: word op with addr[1:0]!=0; half op with addr[0]!=0.
REQ-010 In REQ: mem_req=1 and M_stall=1; mem_addr, mem_we, mem_byteen and mem_wdata SHALL be held stable until mem_ready is sampled 1.
REQ-011 REQ with mem_ready=1 SHALL go to DONE on that edge; a load SHALL capture the extended mem_rdata into M_ldata on the same edge.
REQ-012 REQ with mem_ready=0 SHALL stay in REQ; there is no timeout.
REQ-013 DONE: M_stall=0 and mem_req=0; M_ldata_valid=1 for loads only; leave to IDLE when M_hold=0, else stay in DONE with M_ldata held.
REQ-014 mem_addr SHALL equal {M_ALUout[31:2],2'b00}.
REQ-015 Byte enables: SW 4'b1111; SH 4'b0011<<(2*addr[1]); SB 4'b0001<<addr[1:0]; loads 4'b0000 with mem_we=0.
REQ-016 mem_wdata SHALL replicate the store data into the enabled lanes: SW r2; SH {2{r2[15:0]}}; SB {4{r2[7:0]}}.
REQ-017 Loads SHALL select the lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend to 32 bits.
REQ-018 mem_ready asserted while not in REQ SHALL be ignored.
REQ-019 A one-cycle M_stall SHALL never reach the pipeline before the request.

Reset
REQ-020 reset=0 SHALL force IDLE immediately, independent of clk.
REQ-021 During reset, mem_req=0, mem_we=0, mem_byteen=0, M_ldata=0, M_ldata_valid=0, M_stall=0, M_excAdEL=0, M_excAdES=0.
REQ-022 Reset asserted mid-REQ SHALL abandon the transaction; the memory side tolerates the dropped mem_req.
REQ-023 After reset deassertion, the first edge SHALL evaluate IDLE decode normally.

Structure
REQ-024 Opcode constants and FSM state encodings SHALL live in the shared CPU definitions package.
REQ-025 Load lane select/extension SHALL be a sub-module named load_ext (combinational).
REQ-026 Store lane/byte-enable generation SHALL stay inside m_mem_ctrl.

Verification
REQ-027 SW, addr 0x0000_0104, r2=0xDEADBEEF, mem_ready high 1 cycle later -> mem_addr 0x104, byteen 1111, wdata 0xDEADBEEF; M_stall high for exactly 2 cycles.
REQ-028 LB, addr 0x0000_0203, rdata 0x80FF_1234 -> M_ldata 0xFFFF_FF80 with M_ldata_valid=1 in DONE; the LBU variant gives 0x0000_0080.
REQ-029 SH, addr 0x0000_0012, r2=0x0000_ABCD -> byteen 1100, wdata 0xABCD_ABCD.
REQ-030 LW, addr 0x0000_0006 -> M_excAdEL=1, mem_req never asserts, M_stall=0.
REQ-031 LH with mem_ready held low 5 cycles -> mem_req and M_stall high all 5+1 cycles, with address stable throughout; M_hold=1 in DONE -> DONE held and M_ldata stable.
REQ-032 reset pulsed low mid-REQ -> mem_req=0 and M_stall=0 immediately; the next SW after release completes normally.
